// File: rtl/switch_bounce_pkg.sv
// Shared types and constants for the switch bounce generator.
package switch_bounce_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPressBounce,
    StHold,
    StReleaseBounce
  } state_e;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LfsrTaps = 16'hB400;

  localparam logic [15:0] DefaultSeed = 16'hACE1;

endpackage

// File: rtl/bounce_lfsr.sv
// 16-bit Fibonacci LFSR: loads the seed on reset, shifts once per advance.
module bounce_lfsr
  import switch_bounce_pkg::*;
#(
  parameter logic [15:0] SEED = DefaultSeed
) (
  input  logic        in_clk,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] value
);

  // An all-zero state would lock the register up, so it is swapped for 1.
  localparam logic [15:0] SeedEff = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q, lfsr_d;
  logic        feedback;

  // Next value: shift in the XOR of the tapped bits when advancing.
  always_comb begin
    feedback = ^(lfsr_q & LfsrTaps);
    lfsr_d   = lfsr_q;
    if (advance) begin
      lfsr_d = {lfsr_q[14:0], feedback};
    end
  end

  // State register with synchronous seed load.
  always_ff @(posedge in_clk) begin
    if (reset) begin
      lfsr_q <= SeedEff;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/switch_bounce_gen.sv
// Emulates a bouncing mechanical key: press edge, bounce toggles, hold, release
// edge, bounce toggles. Define SWITCH_BOUNCE_LFSR_EN for pseudo-random gaps
// (1 + lfsr[GAP_W-1:0]); otherwise every gap is 2**(GAP_W-1) cycles.
module switch_bounce_gen
  import switch_bounce_pkg::*;
#(
  parameter int unsigned BOUNCE_EDGES = 4,
  parameter int unsigned GAP_W        = 3,
  parameter logic [15:0] SEED         = DefaultSeed
) (
  input  logic        in_clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [15:0] req_hold,
  output logic        req_ready,
  output logic        sw_out,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] Toggles = 8'(BOUNCE_EDGES);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] hold_q, hold_d;
  logic [7:0]  tog_q, tog_d;
  logic        sw_q, sw_d;
  logic        done_q, done_d;
  logic        ready_q, busy_q;
  logic        gap_load;
  logic [15:0] gap;
  logic [15:0] hold_eff;

`ifdef SWITCH_BOUNCE_LFSR_EN
  logic [15:0] lfsr_value;
  logic        unused_lfsr_bits;

  bounce_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .in_clk (in_clk),
    .reset  (reset),
    .advance(gap_load),
    .value  (lfsr_value)
  );

  assign gap              = 16'(lfsr_value[GAP_W-1:0]) + 16'd1;
  assign unused_lfsr_bits = ^lfsr_value[15:GAP_W];
`else
  localparam logic [15:0] GapFixed = 16'd1 << (GAP_W - 1);
  logic unused_gap_load;

  assign gap             = GapFixed;
  assign unused_gap_load = gap_load;
`endif

  assign hold_eff = (req_hold == 16'd0) ? 16'd1 : req_hold;

  // Next-state logic. cnt_q == 1 marks the edge where the next level change lands.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    tog_d    = tog_q;
    sw_d     = sw_q;
    done_d   = 1'b0;
    gap_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          sw_d   = 1'b1;
          hold_d = hold_eff;
          if (Toggles != 8'd0) begin
            state_d  = StPressBounce;
            cnt_d    = gap;
            gap_load = 1'b1;
            tog_d    = Toggles;
          end else begin
            state_d = StHold;
            cnt_d   = hold_eff;
          end
        end
      end
      StPressBounce: begin
        if (cnt_q == 16'd1) begin
          sw_d  = ~sw_q;
          tog_d = tog_q - 8'd1;
          if (tog_q == 8'd1) begin
            state_d = StHold;
            cnt_d   = hold_q;
          end else begin
            cnt_d    = gap;
            gap_load = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StHold: begin
        if (cnt_q == 16'd1) begin
          sw_d = 1'b0;
          if (Toggles != 8'd0) begin
            state_d  = StReleaseBounce;
            cnt_d    = gap;
            gap_load = 1'b1;
            tog_d    = Toggles;
          end else begin
            state_d = StIdle;
            cnt_d   = 16'd0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StReleaseBounce: begin
        if (cnt_q == 16'd1) begin
          sw_d  = ~sw_q;
          tog_d = tog_q - 8'd1;
          if (tog_q == 8'd1) begin
            state_d = StIdle;
            cnt_d   = 16'd0;
            done_d  = 1'b1;
          end else begin
            cnt_d    = gap;
            gap_load = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; ready/busy follow the state being entered.
  always_ff @(posedge in_clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 16'd0;
      hold_q  <= 16'd0;
      tog_q   <= 8'd0;
      sw_q    <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      tog_q   <= tog_d;
      sw_q    <= sw_d;
      done_q  <= done_d;
      ready_q <= (state_d == StIdle);
      busy_q  <= (state_d != StIdle);
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign sw_out    = sw_q;
  assign done      = done_q;

endmodule
